// File: rtl/lzrw1_pkg.sv
// Shared types and constants for the LZRW1 stream front end.
package lzrw1_pkg;

    localparam int CW_BITS = 16;

    localparam logic LITERAL = 1'b0;
    localparam logic COPY    = 1'b1;

    typedef enum logic [2:0] {
        S_CW_LO = 3'd0,
        S_CW_HI = 3'd1,
        S_ITEM0 = 3'd2,
        S_ITEM1 = 3'd3,
        S_ISSUE = 3'd4,
        S_GAP   = 3'd5
    } unpack_state_t;

    typedef struct packed {
        logic [15:0] data;
        logic        is_copy;
    } item_t;

endpackage

// File: rtl/lzrw1_item_unpacker.sv
// Splits a raw LZRW1 byte stream into control words and items, and issues
// each item to the decompressor paced by its busy signal.
module lzrw1_item_unpacker
    import lzrw1_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] data_in,
    output logic        control_word_in,
    output logic        data_in_valid,
    input  logic        decompressor_busy,
    output logic        stream_done,
    output logic        format_error,
    output logic [15:0] items_issued
);

    unpack_state_t state_q, state_d;
    logic [CW_BITS-1:0] cw_q, cw_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         byte0_q, byte0_d;
    logic               last_pending_q, last_pending_d;
    item_t              item_q, item_d;
    logic               err_q, err_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               ready_state_s;
    logic               accept_s;
    logic               issue_s;
    logic               done_s;

    // Byte acceptance is only possible in the parsing states; gated by reset
    // so the port reads low while reset is held.
    always_comb begin
        ready_state_s = (state_q == S_CW_LO) || (state_q == S_CW_HI) ||
                        (state_q == S_ITEM0) || (state_q == S_ITEM1);
    end

    assign in_ready = reset & ready_state_s;
    assign accept_s = in_valid & in_ready;

    // Next-state and datapath update for the stream parser.
    always_comb begin
        state_d        = state_q;
        cw_d           = cw_q;
        idx_d          = idx_q;
        byte0_d        = byte0_q;
        last_pending_d = last_pending_q;
        item_d         = item_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        issue_s        = 1'b0;
        done_s         = 1'b0;
        case (state_q)
            S_CW_LO: begin
                if (accept_s) begin
                    cw_d[7:0] = in_byte;
                    if (in_last) begin
                        err_d  = 1'b1;
                        done_s = 1'b1;
                    end else begin
                        state_d = S_CW_HI;
                    end
                end else begin
                    state_d = S_CW_LO;
                end
            end
            S_CW_HI: begin
                if (accept_s) begin
                    cw_d[15:8] = in_byte;
                    idx_d      = 4'd0;
                    if (in_last) begin
                        done_s  = 1'b1;
                        state_d = S_CW_LO;
                    end else begin
                        state_d = S_ITEM0;
                    end
                end else begin
                    state_d = S_CW_HI;
                end
            end
            S_ITEM0: begin
                if (accept_s) begin
                    if (cw_q[idx_q] == LITERAL) begin
                        item_d.data    = {8'h00, in_byte};
                        item_d.is_copy = LITERAL;
                        last_pending_d = in_last;
                        state_d        = S_ISSUE;
                    end else if (in_last) begin
                        // Copy item cut short: nothing is issued for it.
                        byte0_d = in_byte;
                        err_d   = 1'b1;
                        done_s  = 1'b1;
                        state_d = S_CW_LO;
                    end else begin
                        byte0_d = in_byte;
                        state_d = S_ITEM1;
                    end
                end else begin
                    state_d = S_ITEM0;
                end
            end
            S_ITEM1: begin
                if (accept_s) begin
                    item_d.data    = {byte0_q, in_byte};
                    item_d.is_copy = COPY;
                    last_pending_d = in_last;
                    state_d        = S_ISSUE;
                end else begin
                    state_d = S_ITEM1;
                end
            end
            S_ISSUE: begin
                if (!decompressor_busy) begin
                    issue_s = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_GAP;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_GAP: begin
                // Dead cycle: busy from the decompressor lags the strobe by one.
                if (last_pending_q) begin
                    done_s         = 1'b1;
                    last_pending_d = 1'b0;
                    state_d        = S_CW_LO;
                end else if (idx_q == 4'(CW_BITS - 1)) begin
                    state_d = S_CW_LO;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_ITEM0;
                end
            end
            default: begin
                state_d = S_CW_LO;
            end
        endcase
    end

    // Parser state and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_CW_LO;
            cw_q           <= '0;
            idx_q          <= 4'd0;
            byte0_q        <= 8'h00;
            last_pending_q <= 1'b0;
            item_q         <= '0;
            err_q          <= 1'b0;
            cnt_q          <= 16'h0000;
        end else begin
            state_q        <= state_d;
            cw_q           <= cw_d;
            idx_q          <= idx_d;
            byte0_q        <= byte0_d;
            last_pending_q <= last_pending_d;
            item_q         <= item_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign data_in         = item_q.data;
    assign control_word_in = item_q.is_copy;
    assign data_in_valid   = issue_s;
    assign stream_done     = done_s;
    assign format_error    = err_q;
    assign items_issued    = cnt_q;

endmodule
